cpu_trace_uart: RTL
===================

# cpu_trace_uart

Downstream trace stage for the CPU top level. It watches the program counter and the two register-file read ports that drive the LEDs. Each time the PC changes, it snapshots {PC, read_a, read_b} into a small FIFO and streams the snapshot out of a serial 8N1 UART pin. This gives a host-side execution trace without touching the datapath. The block is purely an observer: it never back-pressures or stalls the CPU.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, 8: snapshot entries buffered; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0); clears all state immediately, independent of clk.
- en  in  1  trace enable; captures occur only while 1.
- pc_addr  in  8  CPU program counter.
- read_a  in  8  register-file read port A.
- read_b  in  8  register-file read port B.
- tx  out  1  UART serial output, idle high.
- busy  out  1  1 while the FIFO is non-empty or the transmitter is not IDLE.
- overflow  out  1  sticky; set when a capture is dropped because the FIFO is full; cleared only by rst.

## Operation
- Capture unit:
  - Holds pc_last[7:0] and a first flag (set by reset).
  - On each clk edge, a capture condition exists when first=1 or pc_addr≠pc_last.
  - pc_last is always loaded with pc_addr, and first is cleared, whether or not en=1.
  - If the condition holds and en=1, push the 24-bit entry {pc_addr, read_a, read_b}, using input values sampled on that edge.
- FIFO:
  - FIFO_DEPTH × 24 bits, circular read/write pointers with an extra wrap bit.
  - A push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
  - A rejected push is discarded and sets overflow.
  - A simultaneous push and pop on an empty FIFO is impossible, because a pop requires non-empty.
- Transmit FSM, with states IDLE, START, DATA, STOP plus a byte index 0..3:
  - IDLE: if the FIFO is non-empty, pop the head into a 24-bit shadow register, set byte index to 0, and go to START.
  - Byte sequence per entry: 0xA5 (sync), pc, read_a, read_b.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB-first, each for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index <3, increment it and go to START. Otherwise go to IDLE.
  - Counters: a bit-time counter (0..CLKS_PER_BIT-1) and a bit index (0..7), both wrapping to 0 at each state change.
- en=0 mid-stream: the in-flight entry and the FIFO contents drain completely; only new pushes are suppressed.
- Reset values: tx=1, busy=0, overflow=0, FIFO empty, FSM=IDLE, first=1, pc_last=0.
- Reset mid-frame: the frame is truncated immediately, tx returns to 1 asynchronously, and buffered entries are lost.

## Timing
- A PC change visible before edge N is pushed at edge N.
- In IDLE with a non-empty FIFO, the pop happens at the next edge E. tx goes low starting in the cycle after E.
- One byte takes 10×CLKS_PER_BIT cycles. One entry takes 40×CLKS_PER_BIT cycles, with no gaps between its four bytes.
- Consecutive entries are separated by exactly one idle-high cycle (the IDLE pop cycle).
- Sustained capacity is one PC change per 40×CLKS_PER_BIT+1 cycles. Faster bursts are absorbed up to FIFO_DEPTH entries plus one in flight; beyond that they set overflow.
- busy is registered. It rises at the push edge and falls at the edge where STOP of byte 3 returns the FSM to IDLE with the FIFO empty.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
1. Reset held, then released with pc=0x00, a=0x11, b=0x22, en=1, all static -> tx=1, busy=0, overflow=0 during reset. Exactly one entry is sent: bytes A5 00 11 22 over 160 cycles. busy then falls and no further frames appear.
2. Bit-level check of the sync byte -> tx sequence is 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop), each level held exactly 4 cycles.
3. PC incremented every cycle from 0x10 for 20 cycles with en=1 -> entries for pc 0x10..0x18 (9 entries: 1 in flight + 8 buffered) are transmitted in order. overflow=1 stays set after the FIFO drains.
4. en=0 while PC steps 0x20→0x25, then en=1 with PC static -> no frames. Then one PC change to 0x26 -> exactly one entry with pc=0x26.
5. rst asserted during DATA of the second byte with 3 entries queued -> tx=1 immediately, without waiting for clk. busy=0. After release with PC static, one entry is sent (because first=1).
6. PC change on the same edge as an IDLE pop with the FIFO full -> push accepted and overflow stays 0. The FIFO remains full and entry order is preserved.

Source files
------------

// File: rtl/cpu_trace_uart.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_uart
// Description : Snapshots {pc, read_a, read_b} on every PC change into a FIFO
//               and streams each entry as A5,pc,a,b bytes over an 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] pc_addr,
  input  logic [7:0] read_a,
  input  logic [7:0] read_b,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_bit_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   c_ptr_one  = 1;
  localparam logic [7:0]    c_sync     = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]    pc_last_q;
  logic          first_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [23:0]   mem_q [FIFO_DEPTH];
  state_t        state_q;
  logic [1:0]    byte_idx_q;
  logic [2:0]    bit_idx_q;
  logic [CW-1:0] cnt_q;
  logic [23:0]   shadow_q;
  logic          tx_q;
  logic          busy_q, busy_d;
  logic          overflow_q;

  logic          w_capture, w_empty, w_full, w_pop, w_push;
  logic          w_bit_done, w_to_idle;
  logic [7:0]    w_byte;

  always_comb begin
    w_capture  = en && (first_q || (pc_addr != pc_last_q));
    w_empty    = (wr_ptr_q == rd_ptr_q);
    w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    w_pop      = (state_q == S_IDLE) && !w_empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    w_push     = w_capture && (!w_full || w_pop);
    wr_ptr_d   = w_push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
    rd_ptr_d   = w_pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
    w_bit_done = (cnt_q == c_bit_last);
    w_to_idle  = ((state_q == S_IDLE) && !w_pop) ||
                 ((state_q == S_STOP) && w_bit_done && (byte_idx_q == 2'd3));
    busy_d     = (wr_ptr_d != rd_ptr_d) || !w_to_idle;
    case (byte_idx_q)
      2'd0:    w_byte = c_sync;
      2'd1:    w_byte = shadow_q[23:16];
      2'd2:    w_byte = shadow_q[15:8];
      default: w_byte = shadow_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_last_q  <= '0;
      first_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pc_last_q  <= pc_addr;
      first_q    <= 1'b0;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      if (w_capture && !w_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {pc_addr, read_a, read_b};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
          if (w_pop) begin
            shadow_q   <= mem_q[rd_ptr_q[AW-1:0]];
            byte_idx_q <= '0;
            state_q    <= S_START;
            tx_q       <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
            tx_q      <= w_byte[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= S_STOP;
              tx_q      <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= w_byte[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            cnt_q <= '0;
            if (byte_idx_q == 2'd3) begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= S_START;
              tx_q       <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire
